decode_scoreboard: RTL

- Parametrised successor to the scalar decode stage: register file with multi-port writeback, per-register pending-write counters, and a condition-code scoreboard.
- Counters replace single valid bits, so several writes to one register may be in flight at once.
- Sits between fetch and execute. Issues decoded operand bundles into a registered valid/stall pipeline slot, and raises a dependency stall to fetch.
- Same-cycle writeback data is forwarded into the operand read.

---
 rtl/decode_scoreboard_pkg.sv | 27 ++
 rtl/decode_scoreboard_if.sv | 58 +++++
 rtl/decode_scoreboard_pend_counter.sv | 38 +++
 rtl/decode_scoreboard.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/decode_scoreboard_pkg.sv
// Shared definitions for the decode/scoreboard slice: default geometry,
// condition-code encodings and the control half of the issue slot.
package decode_pkg;

    localparam int unsigned DEF_NUM_REGS  = 16;
    localparam int unsigned DEF_REG_WIDTH = 16;
    localparam int unsigned DEF_NUM_WB    = 2;
    localparam int unsigned REG_IDX_W     = $clog2(DEF_NUM_REGS);

    localparam int unsigned PC_W = 16;
    localparam int unsigned IR_W = 32;
    localparam int unsigned CC_W = 3;

    localparam logic [CC_W-1:0] CC_N = 3'b100;
    localparam logic [CC_W-1:0] CC_Z = 3'b010;
    localparam logic [CC_W-1:0] CC_P = 3'b001;

    // Width-independent fields of the issued bundle; operands and the
    // destination index are sized by the instantiating module.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [IR_W-1:0] ir;
        logic            dest_en;
        logic [CC_W-1:0] cc;
    } slot_ctrl_t;

endpackage

// File: rtl/decode_scoreboard_if.sv
// Fetch/writeback-facing bus of the decode scoreboard; master drives the
// instruction and writeback inputs, slave is the decode stage.
interface decode_scoreboard_if
    import decode_pkg::*;
#(
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned REG_WIDTH = DEF_REG_WIDTH,
    parameter int unsigned NUM_WB    = DEF_NUM_WB
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic                        I_Valid;
    logic [PC_W-1:0]             I_PC;
    logic [IR_W-1:0]             I_IR;
    logic [IDX_W-1:0]            I_SrcAIdx;
    logic [IDX_W-1:0]            I_SrcBIdx;
    logic                        I_SrcAEn;
    logic                        I_SrcBEn;
    logic [IDX_W-1:0]            I_DestIdx;
    logic                        I_DestEn;
    logic                        I_CCRead;
    logic                        I_CCWrite;
    logic                        I_Flush;
    logic                        I_DownStall;
    logic [NUM_WB-1:0]           I_WBEn;
    logic [NUM_WB*IDX_W-1:0]     I_WBIdx;
    logic [NUM_WB*REG_WIDTH-1:0] I_WBData;
    logic                        I_WBCCEn;
    logic [CC_W-1:0]             I_WBCC;

    logic                        O_DepStall;
    logic                        O_Valid;
    logic [PC_W-1:0]             O_PC;
    logic [IR_W-1:0]             O_IR;
    logic [REG_WIDTH-1:0]        O_SrcAValue;
    logic [REG_WIDTH-1:0]        O_SrcBValue;
    logic [IDX_W-1:0]            O_DestIdx;
    logic                        O_DestEn;
    logic [CC_W-1:0]             O_CCValue;
    logic                        O_Underflow;

    modport master (
        output I_Valid, I_PC, I_IR, I_SrcAIdx, I_SrcBIdx, I_SrcAEn, I_SrcBEn,
               I_DestIdx, I_DestEn, I_CCRead, I_CCWrite, I_Flush, I_DownStall,
               I_WBEn, I_WBIdx, I_WBData, I_WBCCEn, I_WBCC,
        input  O_DepStall, O_Valid, O_PC, O_IR, O_SrcAValue, O_SrcBValue,
               O_DestIdx, O_DestEn, O_CCValue, O_Underflow
    );

    modport slave (
        input  I_Valid, I_PC, I_IR, I_SrcAIdx, I_SrcBIdx, I_SrcAEn, I_SrcBEn,
               I_DestIdx, I_DestEn, I_CCRead, I_CCWrite, I_Flush, I_DownStall,
               I_WBEn, I_WBIdx, I_WBData, I_WBCCEn, I_WBCC,
        output O_DepStall, O_Valid, O_PC, O_IR, O_SrcAValue, O_SrcBValue,
               O_DestIdx, O_DestEn, O_CCValue, O_Underflow
    );

endinterface

// File: rtl/decode_scoreboard_pend_counter.sv
// Pending-write counter: +1 on issue, -dec on writeback hits, clamps at 0
// and flags the clamp. Saturation at the top is prevented by the caller.
module pend_counter #(
    parameter int unsigned PEND_W = 2,
    parameter int unsigned DEC_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [DEC_W-1:0]  dec,
    output logic [PEND_W-1:0] count,
    output logic              full,
    output logic              underflow
);
    localparam int unsigned SUM_W = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;

    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] down;

    always_comb begin
        up        = SUM_W'(count) + SUM_W'(inc);
        down      = SUM_W'(dec);
        underflow = down > up;
    end

    assign full = &count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (underflow) begin
            count <= '0;
        end else begin
            count <= PEND_W'(up - down);
        end
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode stage with multi-port writeback register file, per-register
// pending-write counters, CC scoreboard and a registered issue slot.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_WIDTH = 16,
    parameter int unsigned NUM_WB    = 2,
    parameter int unsigned PEND_W    = 2
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET,
    decode_scoreboard_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned HIT_W = $clog2(NUM_WB + 1);

    logic [REG_WIDTH-1:0] rf      [NUM_REGS];
    logic [HIT_W-1:0]     hits    [NUM_REGS];
    logic [PEND_W-1:0]    pend    [NUM_REGS];
    logic                 full    [NUM_REGS];
    logic                 uflow   [NUM_REGS];
    logic                 inc     [NUM_REGS];
    logic [IDX_W-1:0]     wb_idx  [NUM_WB];
    logic [REG_WIDTH-1:0] wb_data [NUM_WB];

    logic [PEND_W-1:0]    cc_pend;
    logic                 cc_full, cc_uflow, cc_inc;
    logic [CC_W-1:0]      cc_reg, cc_fwd;
    logic                 haz_a, haz_b, haz_cc, haz_ovf, hazard, issue, any_uflow;
    logic [REG_WIDTH-1:0] fwd_a, fwd_b;

    slot_ctrl_t           slot;
    logic [REG_WIDTH-1:0] slot_a, slot_b;
    logic [IDX_W-1:0]     slot_dest;
    logic                 slot_valid, sticky_uflow;

    for (genvar p = 0; p < NUM_WB; p++) begin : g_wb
        assign wb_idx[p]  = bus.I_WBIdx[p*IDX_W +: IDX_W];
        assign wb_data[p] = bus.I_WBData[p*REG_WIDTH +: REG_WIDTH];
    end

    function automatic logic still_pending(input logic [PEND_W-1:0] cnt,
                                           input logic [HIT_W-1:0]  h);
        return 32'(cnt) > 32'(h);
    endfunction

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            hits[r] = '0;
            for (int unsigned p = 0; p < NUM_WB; p++) begin
                if (bus.I_WBEn[p] && wb_idx[p] == IDX_W'(r)) hits[r] = hits[r] + HIT_W'(1);
            end
        end
    end

    // Source hazards look through this cycle's writebacks; the overflow
    // guard deliberately does not, so a full counter never wraps.
    always_comb begin
        haz_a   = bus.I_SrcAEn && still_pending(pend[bus.I_SrcAIdx], hits[bus.I_SrcAIdx]);
        haz_b   = bus.I_SrcBEn && still_pending(pend[bus.I_SrcBIdx], hits[bus.I_SrcBIdx]);
        haz_cc  = bus.I_CCRead && (32'(cc_pend) > 32'(bus.I_WBCCEn));
        haz_ovf = bus.I_DestEn && full[bus.I_DestIdx];
        hazard  = haz_a || haz_b || haz_cc || haz_ovf;
        issue   = bus.I_Valid && !bus.I_Flush && !hazard && !(slot_valid && bus.I_DownStall);
    end

    assign bus.O_DepStall = bus.I_Valid && !bus.I_Flush && hazard;

    always_comb begin
        fwd_a = rf[bus.I_SrcAIdx];
        fwd_b = rf[bus.I_SrcBIdx];
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (bus.I_WBEn[p] && wb_idx[p] == bus.I_SrcAIdx) fwd_a = wb_data[p];
            if (bus.I_WBEn[p] && wb_idx[p] == bus.I_SrcBIdx) fwd_b = wb_data[p];
        end
        cc_fwd = bus.I_WBCCEn ? bus.I_WBCC : cc_reg;
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc[r] = issue && bus.I_DestEn && (bus.I_DestIdx == IDX_W'(r));
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        pend_counter #(.PEND_W(PEND_W), .DEC_W(HIT_W)) u_pend (
            .clk(I_CLOCK), .rst(I_RESET), .inc(inc[r]), .dec(hits[r]),
            .count(pend[r]), .full(full[r]), .underflow(uflow[r])
        );
    end

    // CC writers are not stalled, so the count saturates instead.
    assign cc_inc = issue && bus.I_CCWrite && !(cc_full && !bus.I_WBCCEn);

    pend_counter #(.PEND_W(PEND_W), .DEC_W(1)) u_cc_pend (
        .clk(I_CLOCK), .rst(I_RESET), .inc(cc_inc), .dec(bus.I_WBCCEn),
        .count(cc_pend), .full(cc_full), .underflow(cc_uflow)
    );

    always_comb begin
        any_uflow = cc_uflow;
        for (int unsigned r = 0; r < NUM_REGS; r++) any_uflow = any_uflow | uflow[r];
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) rf[r] <= '0;
            cc_reg       <= '0;
            sticky_uflow <= 1'b0;
            slot         <= '0;
            slot_a       <= '0;
            slot_b       <= '0;
            slot_dest    <= '0;
            slot_valid   <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_WB; p++) begin
                if (bus.I_WBEn[p]) rf[wb_idx[p]] <= wb_data[p];
            end
            if (bus.I_WBCCEn) cc_reg <= bus.I_WBCC;
            if (any_uflow) sticky_uflow <= 1'b1;
            if (issue) begin
                slot.pc      <= bus.I_PC;
                slot.ir      <= bus.I_IR;
                slot.dest_en <= bus.I_DestEn;
                slot.cc      <= cc_fwd;
                slot_a       <= fwd_a;
                slot_b       <= fwd_b;
                slot_dest    <= bus.I_DestIdx;
                slot_valid   <= 1'b1;
            end else if (slot_valid && !bus.I_DownStall) begin
                slot_valid   <= 1'b0;
            end
        end
    end

    assign bus.O_Valid     = slot_valid;
    assign bus.O_PC        = slot.pc;
    assign bus.O_IR        = slot.ir;
    assign bus.O_SrcAValue = slot_a;
    assign bus.O_SrcBValue = slot_b;
    assign bus.O_DestIdx   = slot_dest;
    assign bus.O_DestEn    = slot.dest_en;
    assign bus.O_CCValue   = slot.cc;
    assign bus.O_Underflow = sticky_uflow;

endmodule
